// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - request/result bundle between EX control and the iterative mul/div unit
//
// Purpose: groups the operation request, annul, stall and result signals of muldiv_iter.
// Ports (signals):
//   start_i, op_i, opdata1_i, opdata2_i, annul_i : request side, driven by the master (EX control)
//   stallreq_o, busy_o, ready_o, result_o, div_zero_o : status/result side, driven by the slave (unit)
// Modports: master (EX control / testbench), slave (muldiv_iter).

interface muldiv_iter_if #(
   parameter int WIDTH = 32
);
   logic               start_i;
   logic [1:0]         op_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               annul_i;
   logic               stallreq_o;
   logic               busy_o;
   logic               ready_o;
   logic [2*WIDTH-1:0] result_o;
   logic               div_zero_o;

   modport master (
      output start_i, op_i, opdata1_i, opdata2_i, annul_i,
      input  stallreq_o, busy_o, ready_o, result_o, div_zero_o
   );

   modport slave (
      input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
      output stallreq_o, busy_o, ready_o, result_o, div_zero_o
   );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - shared radix-2 iterative multiply/divide unit for the EX stage
//
// Purpose: signed/unsigned MULT/DIV over one shift-add / restoring-divide datapath,
//          with annul, divide-by-zero detection and a pipeline stall request.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : muldiv_iter_if.slave
//          start_i/op_i/opdata1_i/opdata2_i : request, sampled in IDLE
//          annul_i    : abort current (CALC/FIX) or requested operation
//          stallreq_o : combinational stall request
//          busy_o     : registered, high in CALC and FIX
//          ready_o    : registered one-cycle pulse with a valid result_o
//          result_o   : multiply {hi,lo} product, divide {remainder, quotient}
//          div_zero_o : registered, high with ready_o when the divisor was zero
// op_i: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU

module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   muldiv_iter_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   // hi_q: upper product half / partial remainder; lo_q: multiplier / dividend-quotient
   logic [WIDTH-1:0]   hi_q, lo_q, b_q;
   logic [1:0]         op_q;
   logic               sign_a_q, sign_b_q;
   logic               busy_q, ready_q, div_zero_q;
   logic [2*WIDTH-1:0] result_q;

   logic               accept;
   logic               in_div, in_signed, in_div_zero;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_nxt;
   logic [2*WIDTH-1:0] prod, prod_fix, fix_result;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               diff_signs;

   assign in_div      = bus.op_i[1];
   assign in_signed   = ~bus.op_i[0];
   assign in_div_zero = in_div && (bus.opdata2_i == '0);
   assign accept      = (state_q == S_IDLE) && bus.start_i && !bus.annul_i;

   // Magnitudes: a signed MIN stays MIN, which is the correct unsigned magnitude.
   assign mag_a = (in_signed && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign mag_b = (in_signed && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

   // Multiply step: add multiplicand into the upper half when the current multiplier
   // bit is set, then shift the {carry, hi, lo} pair right by one.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);

   // Restoring divide step on {rem, dividend} shifted left by one.
   assign div_shift   = {hi_q, lo_q[WIDTH-1]};
   assign div_diff    = div_shift - {1'b0, b_q};
   assign div_ge      = ~div_diff[WIDTH];
   assign div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

   // Sign fix-up applied on the FIX -> DONE edge.
   assign diff_signs = sign_a_q ^ sign_b_q;
   assign prod       = {hi_q, lo_q};
   assign prod_fix   = (op_q == 2'b00 && diff_signs) ? -prod : prod;
   assign quo_fix    = (op_q == 2'b10 && diff_signs) ? -lo_q : lo_q;
   assign rem_fix    = (op_q == 2'b10 && sign_a_q) ? -hi_q : hi_q;
   assign fix_result = op_q[1] ? {rem_fix, quo_fix} : prod_fix;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = in_div_zero ? S_DONE : S_CALC;
         S_CALC: begin
            if (bus.annul_i)                   state_d = S_IDLE;
            else if (cnt_q == CW'(WIDTH - 1))  state_d = S_FIX;
         end
         S_FIX:  state_d = bus.annul_i ? S_IDLE : S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      bus.stallreq_o = accept || (state_q == S_CALC) || (state_q == S_FIX);
   end

   assign bus.busy_o     = busy_q;
   assign bus.ready_o    = ready_q;
   assign bus.result_o   = result_q;
   assign bus.div_zero_o = div_zero_q;

   // Datapath and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         b_q        <= '0;
         op_q       <= '0;
         sign_a_q   <= 1'b0;
         sign_b_q   <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         div_zero_q <= 1'b0;
         result_q   <= '0;
      end else begin
         busy_q     <= (state_d == S_CALC) || (state_d == S_FIX);
         ready_q    <= (state_d == S_DONE);
         // DONE lasts exactly one cycle, so this stays aligned with ready_q.
         div_zero_q <= accept && in_div_zero;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q     <= bus.op_i;
                  sign_a_q <= in_signed && bus.opdata1_i[WIDTH-1];
                  sign_b_q <= in_signed && bus.opdata2_i[WIDTH-1];
                  cnt_q    <= '0;
                  hi_q     <= '0;
                  if (in_div) begin
                     lo_q <= mag_a;
                     b_q  <= mag_b;
                  end else begin
                     lo_q <= mag_b;
                     b_q  <= mag_a;
                  end
                  if (in_div_zero) result_q <= {bus.opdata1_i, {WIDTH{1'b1}}};
               end
            end
            S_CALC: begin
               if (!bus.annul_i) begin
                  cnt_q <= cnt_q + CW'(1);
                  if (op_q[1]) begin
                     hi_q <= div_rem_nxt;
                     lo_q <= {lo_q[WIDTH-2:0], div_ge};
                  end else begin
                     hi_q <= mul_sum[WIDTH:1];
                     lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!bus.annul_i) result_q <= fix_result;
            end
            default: ;
         endcase
      end
   end
endmodule
